wb_arbiter: RTL

Writeback arbiter between the execution units and the register file's single write port. Accepts completed results from three sources (ALU, load unit, multiply/divide) over valid/ready handshakes and selects at most one per cycle by fixed priority with starvation aging. Drives a registered write (we/addr/data) into the register file. Optionally tracks per-register pending-write busy bits for the issue stage's hazard check.

---
 rtl/wb_arbiter_pkg.sv | 27 ++
 rtl/wb_arbiter_age.sv | 32 +++
 rtl/wb_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared writeback constants, source indices and the grant-selection helper.
// A lower source index means a higher base priority.
package wb_arbiter_pkg;

  localparam int WB_XLEN = 32;
  localparam int WB_AW   = 5;
  localparam int WB_NSRC = 3;

  // Source indices, listed in base priority order (mem > mdu > alu).
  typedef enum logic [1:0] {
    SRC_MEM = 2'd0,
    SRC_MDU = 2'd1,
    SRC_ALU = 2'd2
  } src_e;

  // One-hot grant. Urgent requesters outrank all others; within the chosen
  // class the lowest index wins.
  function automatic logic [WB_NSRC-1:0] pick_grant(
    input logic [WB_NSRC-1:0] valid,
    input logic [WB_NSRC-1:0] urgent
  );
    logic [WB_NSRC-1:0] req;
    req = ((valid & urgent) != '0) ? (valid & urgent) : valid;
    return req & (~req + WB_NSRC'(1));
  endfunction

endpackage

// File: rtl/wb_arbiter_age.sv
// wb_age_counter: per-source saturating wait counter. The source becomes
// urgent once it has been stalled for STARVE_LIMIT consecutive cycles.
module wb_age_counter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic valid,
  input  logic ready,
  output logic urgent
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] wait_cnt;

  // Count stalled cycles, saturating; any transfer or idle cycle clears.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt <= '0;
    end else if (!valid || ready) begin
      wait_cnt <= '0;
    end else if (wait_cnt != CW'(STARVE_LIMIT)) begin
      wait_cnt <= wait_cnt + CW'(1);
    end
  end

  assign urgent = (wait_cnt == CW'(STARVE_LIMIT));

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: selects one of mem/mdu/alu results per cycle and drives the
// register file write port through a single output register.
// Optional feature macro: WB_SCOREBOARD_EN adds issue_valid/issue_rd/busy
// and the pending-write bitmap.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int XLEN         = WB_XLEN,
  parameter int AW           = WB_AW,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [AW-1:0]   mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            mdu_valid,
  output logic            mdu_ready,
  input  logic [AW-1:0]   mdu_rd,
  input  logic [XLEN-1:0] mdu_data,
  output logic            rf_we,
  output logic [AW-1:0]   rf_addr,
  output logic [XLEN-1:0] rf_wdata
`ifdef WB_SCOREBOARD_EN
  ,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_rd,
  output logic [(1<<AW)-1:0]    busy
`endif
);

  logic [WB_NSRC-1:0] vld;
  logic [WB_NSRC-1:0] rdy;
  logic [WB_NSRC-1:0] urg;
  logic [AW-1:0]      rd_a   [WB_NSRC];
  logic [XLEN-1:0]    data_a [WB_NSRC];

  assign vld[SRC_MEM]    = mem_valid;
  assign vld[SRC_MDU]    = mdu_valid;
  assign vld[SRC_ALU]    = alu_valid;
  assign rd_a[SRC_MEM]   = mem_rd;
  assign rd_a[SRC_MDU]   = mdu_rd;
  assign rd_a[SRC_ALU]   = alu_rd;
  assign data_a[SRC_MEM] = mem_data;
  assign data_a[SRC_MDU] = mdu_data;
  assign data_a[SRC_ALU] = alu_data;

  for (genvar i = 0; i < WB_NSRC; i++) begin : g_age
    wb_age_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_age (
      .CLK    (CLK),
      .RST    (RST),
      .valid  (vld[i]),
      .ready  (rdy[i]),
      .urgent (urg[i])
    );
  end

  // Combinational grant; nothing is granted while reset is held.
  assign rdy       = RST ? '0 : pick_grant(vld, urg);
  assign mem_ready = rdy[SRC_MEM];
  assign mdu_ready = rdy[SRC_MDU];
  assign alu_ready = rdy[SRC_ALU];

  logic            win_any;
  logic [AW-1:0]   win_rd;
  logic [XLEN-1:0] win_data;

  // Route the granted source's payload to the output register.
  // NOTE: every output gets a default before the loop so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    win_any  = 1'b0;
    win_rd   = '0;
    win_data = '0;
    for (int i = 0; i < WB_NSRC; i++) begin
      if (rdy[i]) begin
        win_any  = 1'b1;
        win_rd   = rd_a[i];
        win_data = data_a[i];
      end
    end
  end

  // Register the write; address/data hold when there is no winner.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rf_we    <= 1'b0;
      rf_addr  <= '0;
      rf_wdata <= '0;
    end else if (win_any) begin
      rf_we    <= (win_rd != '0);
      rf_addr  <= win_rd;
      rf_wdata <= win_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [(1<<AW)-1:0] busy_nxt;

  // Clear on the committing write, then set on issue so a same-register
  // set wins; register 0 never reads as busy.
  always_comb begin
    busy_nxt = busy;
    if (rf_we) busy_nxt[rf_addr] = 1'b0;
    if (issue_valid && (issue_rd != '0)) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Pending-write bitmap register.
  always_ff @(posedge CLK) begin
    if (RST) busy <= '0;
    else     busy <= busy_nxt;
  end
`endif

endmodule
